// File: rtl/dbg_mem_dump_pkg.sv
// Shared types and constants for the BRAM debug-port memory dumper.
// Holds the FSM state encoding and the data word width of the bram32 debug port.
package dbg_mem_dump_pkg;

   localparam int DATA_WIDTH = 32;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_WAIT = 3'd2,
      S_SEND = 3'd3,
      S_DONE = 3'd4
   } dump_state_t;

   // Debug-port addresses are byte addresses, but only whole words are ever read
   function automatic logic [1:0] word_offset_mask();
      return 2'b00;
   endfunction

endpackage

// File: rtl/dbg_mem_dump_chk.sv
// Protocol invariants of the dump stream interface.
// Pure observation: it has no outputs and drives nothing.
module dbg_mem_dump_chk
   import dbg_mem_dump_pkg::*;
(
   input logic                  clk,
   input logic                  rst,
   input logic                  m_valid,
   input logic                  m_ready,
   input logic [DATA_WIDTH-1:0] m_data,
   input logic                  m_last,
   input logic                  busy,
   input logic                  cpu_stall,
   input logic                  done
);

   a_stall_is_busy: assert property (@(posedge clk) disable iff (rst)
      cpu_stall == busy);

   a_last_needs_valid: assert property (@(posedge clk) disable iff (rst)
      m_last |-> m_valid);

   a_done_not_valid: assert property (@(posedge clk) disable iff (rst)
      done |-> !m_valid);

   a_done_while_busy: assert property (@(posedge clk) disable iff (rst)
      done |-> busy);

   // A stalled beat must not change or disappear before it is accepted
   a_hold_beat: assert property (@(posedge clk) disable iff (rst)
      (m_valid && !m_ready) |=> (m_valid && $stable(m_data) && $stable(m_last)));

endmodule

// File: rtl/dbg_mem_dump.sv
// Walks a word range of a bram32 through its debug port and streams the words
// out on a valid/ready interface, holding the core stalled while it runs.
module dbg_mem_dump
   import dbg_mem_dump_pkg::*;
#(
   parameter int ADDR_W       = 10,
   parameter int CNT_W        = 9,
   parameter int READ_LATENCY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [CNT_W-1:0]      word_count,
   output logic [ADDR_W-1:0]     debug_addr,
   input  logic [DATA_WIDTH-1:0] debug_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  cpu_stall,
   output logic                  done
);

   localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'd4};

   dump_state_t               state_r;
   logic [ADDR_W-1:0]         addr_r;
   logic [CNT_W-1:0]          remaining_r;
   logic [DATA_WIDTH-1:0]     m_data_r;
   logic                      m_valid_r;
   logic                      m_last_r;
   logic                      busy_r;
   logic                      done_r;
   logic                      unused_base_lsbs_s;

   assign unused_base_lsbs_s = ^base_addr[1:0];

   // Dump sequencer: address walk, word capture, stream handshake and done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= S_IDLE;
         addr_r      <= {ADDR_W{1'b0}};
         remaining_r <= CNT_ZERO;
         m_data_r    <= {DATA_WIDTH{1'b0}};
         m_valid_r   <= 1'b0;
         m_last_r    <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  busy_r <= 1'b1;
                  if (word_count != CNT_ZERO) begin
                     addr_r      <= {base_addr[ADDR_W-1:2], word_offset_mask()};
                     remaining_r <= word_count;
                     state_r     <= S_ADDR;
                  end else begin
                     done_r  <= 1'b1;
                     state_r <= S_DONE;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            S_ADDR: begin
               // A combinational port already shows the word for the address now on debug_addr
               if (READ_LATENCY == 0) begin
                  m_data_r  <= debug_data;
                  m_valid_r <= 1'b1;
                  m_last_r  <= (remaining_r == CNT_ONE);
                  state_r   <= S_SEND;
               end else begin
                  state_r <= S_WAIT;
               end
            end
            S_WAIT: begin
               m_data_r  <= debug_data;
               m_valid_r <= 1'b1;
               m_last_r  <= (remaining_r == CNT_ONE);
               state_r   <= S_SEND;
            end
            S_SEND: begin
               if (m_ready) begin
                  m_valid_r   <= 1'b0;
                  m_last_r    <= 1'b0;
                  remaining_r <= remaining_r - CNT_ONE;
                  // The address only advances when another read follows, so debug_addr holds after the dump
                  if (remaining_r == CNT_ONE) begin
                     done_r  <= 1'b1;
                     state_r <= S_DONE;
                  end else begin
                     addr_r  <= addr_r + WORD_STEP;
                     state_r <= S_ADDR;
                  end
               end else begin
                  m_valid_r <= 1'b1;
               end
            end
            S_DONE: begin
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               state_r <= S_IDLE;
            end
            default: begin
               m_valid_r <= 1'b0;
               m_last_r  <= 1'b0;
               busy_r    <= 1'b0;
               done_r    <= 1'b0;
               state_r   <= S_IDLE;
            end
         endcase
      end
   end

   assign debug_addr = addr_r;
   assign m_valid    = m_valid_r;
   assign m_data     = m_data_r;
   assign m_last     = m_last_r;
   assign busy       = busy_r;
   assign cpu_stall  = busy_r;
   assign done       = done_r;

   dbg_mem_dump_chk u_chk (
      .clk       (clk),
      .rst       (rst),
      .m_valid   (m_valid_r),
      .m_ready   (m_ready),
      .m_data    (m_data_r),
      .m_last    (m_last_r),
      .busy      (busy_r),
      .cpu_stall (busy_r),
      .done      (done_r)
   );

endmodule

// File: tb/tb_dbg_mem_dump.sv
// Randomized bench for dbg_mem_dump against a word-list model of the dump
// built directly from the memory contents, base address and word count.
module tb_dbg_mem_dump;
   import dbg_mem_dump_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  start;
   logic [9:0]            base_addr;
   logic [8:0]            word_count;
   logic [9:0]            debug_addr;
   logic [DATA_WIDTH-1:0] debug_data;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;
   logic                  busy;
   logic                  cpu_stall;
   logic                  done;

   logic [31:0] mem [0:255];
   assign debug_data = mem[debug_addr[9:2]];

   always #5 clk = ~clk;

   dbg_mem_dump #(.ADDR_W(10), .CNT_W(9), .READ_LATENCY(0)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base_addr),
      .word_count (word_count),
      .debug_addr (debug_addr),
      .debug_data (debug_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .m_last     (m_last),
      .busy       (busy),
      .cpu_stall  (cpu_stall),
      .done       (done)
   );

   typedef struct packed {
      logic [31:0] data;
      logic        last;
   } beat_t;

   int          n_vec = 0;
   int          n_err = 0;
   beat_t       exp_q[$];
   logic [31:0] got_q[$];
   logic [9:0]  addr_log[$];
   int          done_count = 0;
   bit          dump_open = 1'b0;
   int          ready_mode = 0;
   int          beat_idx = 0;
   int          cyc = 0;
   int          rcyc = 0;
   int          last_beat_cyc = 0;
   logic [3:0]  ready_pat = 4'b1001;

   logic        prev_rst = 1'b1;
   logic        prev_valid = 1'b0;
   logic        prev_ready = 1'b0;
   logic        prev_last = 1'b0;
   logic        prev_done = 1'b0;
   logic [31:0] prev_data = 32'h0;
   logic [9:0]  prev_dbg = 10'h0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Sink readiness: 0 = always ready, 1 = random, 2 = repeating 1,0,0,1
   always @(posedge clk) begin
      #1;
      rcyc++;
      case (ready_mode)
         0: m_ready = 1'b1;
         1: m_ready = 1'($urandom_range(0, 1));
         default: m_ready = ready_pat[rcyc % 4];
      endcase
   end

   // Compare process: checks every beat, stall hold and done pulse against the model
   always @(negedge clk) begin
      beat_t b;
      cyc++;
      chk("stall_eq_busy", cpu_stall, busy);
      if (!rst && !prev_rst && prev_valid && !prev_ready) begin
         chk("hold_valid", m_valid, 1'b1);
         chk("hold_data", m_data, prev_data);
         chk("hold_last", m_last, prev_last);
      end
      if (!rst && !prev_rst && prev_done) begin
         chk("done_one_cycle", done, 1'b0);
         chk("busy_after_done", busy, 1'b0);
      end
      if (!rst && busy && debug_addr !== prev_dbg) addr_log.push_back(debug_addr);
      if (m_valid && m_ready && !rst) begin
         chk("beat_expected", exp_q.size() > 0, 1'b1);
         if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            chk("beat_data", m_data, b.data);
            chk("beat_last", m_last, b.last);
         end
         got_q.push_back(m_data);
         if (ready_mode == 0 && beat_idx > 0) chk("beat_gap", cyc - last_beat_cyc, 2);
         last_beat_cyc = cyc;
         beat_idx++;
      end
      if (done && !rst) begin
         done_count++;
         chk("done_expected", dump_open, 1'b1);
         chk("done_after_all_beats", exp_q.size(), 0);
         dump_open = 1'b0;
      end
      prev_rst   = rst;
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_last  = m_last;
      prev_done  = done;
      prev_data  = m_data;
      prev_dbg   = debug_addr;
   end

   task automatic load_model(input logic [9:0] base, input logic [8:0] cnt);
      exp_q.delete();
      got_q.delete();
      addr_log.delete();
      for (int i = 0; i < int'(cnt); i++)
         exp_q.push_back('{data: mem[(int'(base[9:2]) + i) % 256], last: (i == int'(cnt) - 1)});
      beat_idx  = 0;
      dump_open = 1'b1;
   endtask

   task automatic pulse_start(input logic [9:0] base, input logic [8:0] cnt);
      @(posedge clk); #1;
      start = 1'b1; base_addr = base; word_count = cnt;
      @(posedge clk); #1;
      start = 1'b0; base_addr = 10'($urandom); word_count = 9'($urandom);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_debug_addr"}, debug_addr, 10'h0);
      chk({tag, "_m_valid"}, m_valid, 1'b0);
      chk({tag, "_m_data"}, m_data, 32'h0);
      chk({tag, "_m_last"}, m_last, 1'b0);
      chk({tag, "_busy"}, busy, 1'b0);
      chk({tag, "_cpu_stall"}, cpu_stall, 1'b0);
      chk({tag, "_done"}, done, 1'b0);
   endtask

   task automatic do_dump(input logic [9:0] base, input logic [8:0] cnt, input int mode, input bit poke);
      int t0;
      int k;
      ready_mode = mode;
      load_model(base, cnt);
      t0 = done_count;
      pulse_start(base, cnt);
      @(negedge clk);
      chk("n0_busy", busy, 1'b1);
      chk("n0_done", done, cnt == 9'd0);
      chk("n0_valid", m_valid, 1'b0);
      if (cnt != 9'd0) chk("n0_debug_addr", debug_addr, {base[9:2], 2'b00});
      @(negedge clk);
      if (cnt == 9'd0) begin
         chk("n1_busy", busy, 1'b0);
         chk("n1_done", done, 1'b0);
      end else begin
         chk("first_valid_latency", m_valid, 1'b1);
      end
      if (poke && cnt != 9'd0) pulse_start(10'($urandom), 9'($urandom_range(1, 20)));
      k = 0;
      while (done_count == t0 && k < 4000) begin
         @(negedge clk);
         k++;
      end
      chk("dump_completes", done_count - t0, 1);
      repeat (2) @(negedge clk);
      chk("idle_busy", busy, 1'b0);
      chk("idle_valid", m_valid, 1'b0);
   endtask

   task automatic reset_mid_dump();
      int  t0;
      bit  found;
      ready_mode = 0;
      load_model(10'h000, 9'd4);
      pulse_start(10'h000, 9'd4);
      found = 1'b0;
      for (int k = 0; k < 100 && !found; k++) begin
         @(posedge clk); #1;
         if (m_valid && got_q.size() == 1) found = 1'b1;
      end
      chk("rst_reached_beat2", found, 1'b1);
      rst = 1'b1;
      exp_q.delete();
      dump_open = 1'b0;
      t0 = done_count;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_values("midrst");
      repeat (6) @(negedge clk);
      chk("midrst_no_done", done_count, t0);
      chk("midrst_partial_beats", got_q.size(), 1);
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] rb;
      logic [8:0] rc;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      mem[0] = 32'h0000_0011;
      mem[1] = 32'h0000_0022;
      mem[2] = 32'h0000_0033;
      mem[3] = 32'h0000_0001;
      rst = 1'b1; start = 1'b0; base_addr = 10'h0; word_count = 9'h0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_values("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      do_dump(10'h000, 9'd4, 0, 1'b0);
      chk("t1_count", got_q.size(), 4);
      chk("t1_beat0", got_q[0], 32'h0000_0011);
      chk("t1_beat1", got_q[1], 32'h0000_0022);
      chk("t1_beat2", got_q[2], 32'h0000_0033);
      chk("t1_beat3", got_q[3], 32'h0000_0001);

      do_dump(10'h00C, 9'd1, 0, 1'b0);
      chk("t2_count", got_q.size(), 1);
      chk("t2_beat0", got_q[0], 32'h0000_0001);

      do_dump(10'h000, 9'd0, 0, 1'b0);
      chk("t3_no_beats", got_q.size(), 0);

      do_dump(10'h003, 9'd4, 2, 1'b0);
      chk("t4_count", got_q.size(), 4);
      chk("t4_beat0", got_q[0], 32'h0000_0011);
      chk("t4_beat3", got_q[3], 32'h0000_0001);

      do_dump(10'h3FC, 9'd2, 0, 1'b0);
      chk("t5_count", got_q.size(), 2);
      chk("t5_beat1", got_q[1], 32'h0000_0011);
      chk("t5_addr_steps", addr_log.size(), 2);
      chk("t5_addr0", addr_log[0], 10'h3FC);
      chk("t5_addr1", addr_log[1], 10'h000);

      reset_mid_dump();
      do_dump(10'h000, 9'd4, 1, 1'b0);
      chk("t6_redump_count", got_q.size(), 4);
      chk("t6_redump_beat1", got_q[1], 32'h0000_0022);

      for (int n = 0; n < 40; n++) begin
         rb = 10'($urandom);
         if ($urandom_range(0, 3) == 0) rb = 10'h3E0 | 10'($urandom_range(0, 31));
         rc = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 12));
         do_dump(rb, rc, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         chk("rand_beat_count", got_q.size(), int'(rc));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
